multdiv_unit: RTL and testbench

- Parametrised multi-cycle multiply/divide unit for the execute stage; generalises the fixed 32-bit multicycle unit.
- Adds WIDTH/latency parameters, signed/unsigned divide, MADD/MSUB accumulate against a supplied HI/LO, a start/ok handshake and pipeline flush.
- Hazard logic stalls on busy_o; results are consumed on ok_o and forwarded into the memory-stage register.

---
 rtl/multdiv_pkg.sv | 40 ++++
 rtl/radix2_divider.sv | 64 ++++++
 rtl/multdiv_unit.sv | 213 +++++++++++++++++++++
 tb/tb_multdiv_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and opcode helpers for the multi-cycle multiply/divide unit.
package multdiv_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MADD  = 3'd4,
    MD_MADDU = 3'd5,
    MD_MSUB  = 3'd6,
    MD_MSUBU = 3'd7
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_t;

  // Even encodings are the signed flavours of each operation.
  function automatic logic is_signed_op(input md_op_t op);
    return !op[0];
  endfunction

  // MADD/MADDU/MSUB/MSUBU fold the product into the supplied HI/LO.
  function automatic logic is_acc_op(input md_op_t op);
    return op[2];
  endfunction

  function automatic logic is_div_op(input md_op_t op);
    return (op[2:1] == 2'b01);
  endfunction

  function automatic logic is_sub_op(input md_op_t op);
    return (op[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/radix2_divider.sv
// Restoring radix-2 divider datapath: one shift/subtract step per cycle on
// unsigned magnitudes, with the sign fix-up applied to the step result so the
// final quotient/remainder are available in the same cycle as the last step.
module radix2_divider
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             neg_quo_i,
  input  logic             neg_rem_i,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o
);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             neg_quo_q;
  logic             neg_rem_q;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;

  function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  // The partial remainder stays below the divisor, so diff never overflows.
  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    fits   = !diff[WIDTH];
    rem_d  = fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_d  = {quo_q[WIDTH-2:0], fits};
  end

  // Datapath registers: operands loaded on acceptance, then stepped.
  always_ff @(posedge clk) begin
    if (load_i) begin
      rem_q     <= '0;
      quo_q     <= dividend_i;
      dvs_q     <= divisor_i;
      neg_quo_q <= neg_quo_i;
      neg_rem_q <= neg_rem_i;
    end else if (step_i) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

  // Quotient truncates toward zero, remainder follows the dividend's sign.
  assign quo_o = cond_negate(quo_d, neg_quo_q);
  assign rem_o = cond_negate(rem_d, neg_rem_q);

endmodule

// File: rtl/multdiv_unit.sv
// Multi-cycle multiply / divide / multiply-accumulate unit for the execute
// stage, with a valid/ok handshake, busy for hazard stalls and flush.
// Optional build macro DIV_EARLY_EN: skips leading-zero dividend bits so the
// divide latency shrinks to WIDTH-z+1 cycles; results are unchanged.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             valid_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             ok_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX);

  md_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             ok_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  md_op_t           op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] hi_acc_q;
  logic [WIDTH-1:0] lo_acc_q;

  md_op_t           op_in;
  logic             start;
  logic             in_div;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_zero;
  logic [WIDTH-1:0] div_dividend;
  logic [CNT_W-1:0] div_cnt_init;
  logic             div_load;
  logic             div_step;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;

  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mul_res;

`ifdef DIV_EARLY_EN
  // Leading zero count, clamped to WIDTH-1 so a zero dividend still takes one step.
  function automatic logic [CNT_W-1:0] lead_zeros(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] z;
    z = CNT_W'(WIDTH - 1);
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) z = CNT_W'(WIDTH - 1 - i);
    end
    return z;
  endfunction
`endif

  // Acceptance-cycle decode of the incoming request.
  always_comb begin
    op_in    = md_op_t'(op_i);
    start    = (state_q == ST_IDLE) && valid_i && !flush_i;
    in_div   = is_div_op(op_in);
    a_neg    = is_signed_op(op_in) && a_i[WIDTH-1];
    b_neg    = is_signed_op(op_in) && b_i[WIDTH-1];
    a_mag    = a_neg ? (~a_i + 1'b1) : a_i;
    b_mag    = b_neg ? (~b_i + 1'b1) : b_i;
    div_zero = (b_i == '0);
`ifdef DIV_EARLY_EN
    div_dividend = a_mag << lead_zeros(a_mag);
    div_cnt_init = CNT_W'(WIDTH - 1) - lead_zeros(a_mag);
`else
    div_dividend = a_mag;
    div_cnt_init = CNT_W'(WIDTH - 1);
`endif
    div_load = start && in_div && !div_zero;
    div_step = (state_q == ST_DIV);
  end

  // Operand capture; inputs need not be held once the request is accepted.
  always_ff @(posedge clk) begin
    if (start) begin
      op_q     <= op_in;
      a_q      <= a_i;
      b_q      <= b_i;
      hi_acc_q <= hi_i;
      lo_acc_q <= lo_i;
    end
  end

  // Product from the latched operands; treated as a multicycle path of MUL_LAT cycles.
  always_comb begin
    if (is_signed_op(op_q)) begin
      ext_a = {{WIDTH{a_q[WIDTH-1]}}, a_q};
      ext_b = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    end else begin
      ext_a = {{WIDTH{1'b0}}, a_q};
      ext_b = {{WIDTH{1'b0}}, b_q};
    end
    prod = ext_a * ext_b;
    acc  = {hi_acc_q, lo_acc_q};
    if (!is_acc_op(op_q)) begin
      mul_res = prod;
    end else if (is_sub_op(op_q)) begin
      mul_res = acc - prod;
    end else begin
      mul_res = acc + prod;
    end
  end

  radix2_divider #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk        (clk),
    .load_i     (div_load),
    .step_i     (div_step),
    .dividend_i (div_dividend),
    .divisor_i  (b_mag),
    .neg_quo_i  (a_neg ^ b_neg),
    .neg_rem_i  (a_neg),
    .quo_o      (div_quo),
    .rem_o      (div_rem)
  );

  // Control FSM with registered busy/ok and result registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ok_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      ok_q <= 1'b0;
      if (flush_i) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (valid_i) begin
              if (!in_div) begin
                state_q <= ST_MUL;
                cnt_q   <= CNT_W'(MUL_LAT - 1);
                busy_q  <= 1'b1;
              end else if (div_zero) begin
                state_q <= ST_DONE;
                ok_q    <= 1'b1;
                hi_q    <= a_i;
                lo_q    <= '1;
              end else begin
                state_q <= ST_DIV;
                cnt_q   <= div_cnt_init;
                busy_q  <= 1'b1;
              end
            end
          end
          ST_MUL: begin
            if (cnt_q == '0) begin
              state_q      <= ST_DONE;
              busy_q       <= 1'b0;
              ok_q         <= 1'b1;
              {hi_q, lo_q} <= mul_res;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          ST_DIV: begin
            if (cnt_q == '0) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              ok_q    <= 1'b1;
              hi_q    <= div_rem;
              lo_q    <= div_quo;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy_o = busy_q;
  assign ok_o   = ok_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit (WIDTH=32, MUL_LAT=3).
module tb_multdiv_unit;
  import multdiv_pkg::*;

`ifdef DIV_EARLY_EN
  localparam int L_DIV7  = 4;   // |a|=7   -> 29 leading zeros
  localparam int L_DIVU5 = 4;   // a=5     -> 29 leading zeros
  localparam int L_MIN   = 33;  // 0x80000000 -> no leading zeros
  localparam int L_D100  = 8;   // |a|=100 -> 25 leading zeros
  localparam int L_ZERO  = 2;   // a=0 still takes one step
  localparam int L_DFULL = 33;
`else
  localparam int L_DIV7  = 33;
  localparam int L_DIVU5 = 33;
  localparam int L_MIN   = 33;
  localparam int L_D100  = 33;
  localparam int L_ZERO  = 33;
  localparam int L_DFULL = 33;
`endif

  logic        clk;
  logic        resetn;
  logic        valid_i;
  logic [2:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic        flush_i;
  logic        busy_o;
  logic        ok_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int n_vec;
  int n_err;

  multdiv_unit #(
    .WIDTH   (32),
    .MUL_LAT (3)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .valid_i (valid_i),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .hi_i    (hi_i),
    .lo_i    (lo_i),
    .flush_i (flush_i),
    .busy_o  (busy_o),
    .ok_o    (ok_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo);
    valid_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    hi_i    = hi;
    lo_i    = lo;
  endtask

  task automatic scramble();
    valid_i = 1'b0;
    op_i    = 3'($urandom);
    a_i     = $urandom;
    b_i     = $urandom;
    hi_i    = $urandom;
    lo_i    = $urandom;
  endtask

  // Accept at cycle t0, expect busy in t0+1..t0+lat-1 and the ok pulse at t0+lat.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                        input int lat, input logic [31:0] ehi, input logic [31:0] elo);
    @(negedge clk);
    drive(op, a, b, hi, lo);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1) scramble();
      if (k < lat) begin
        chk($sformatf("%s.busy@%0d", tag, k), busy_o, 1);
        chk($sformatf("%s.ok@%0d", tag, k), ok_o, 0);
      end
    end
    chk($sformatf("%s.ok", tag), ok_o, 1);
    chk($sformatf("%s.busy_done", tag), busy_o, 0);
    chk($sformatf("%s.hi", tag), hi_o, ehi);
    chk($sformatf("%s.lo", tag), lo_o, elo);
    @(negedge clk);
    chk($sformatf("%s.ok_pulse", tag), ok_o, 0);
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    resetn  = 1'b1;
    valid_i = 1'b0;
    op_i    = '0;
    a_i     = '0;
    b_i     = '0;
    hi_i    = '0;
    lo_i    = '0;
    flush_i = 1'b0;
    #1 resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.busy", busy_o, 0);
    chk("rst.ok", ok_o, 0);
    chk("rst.hi", hi_o, 0);
    chk("rst.lo", lo_o, 0);
    resetn = 1'b1;

    run_op("mult", MD_MULT, 32'hFFFFFFFF, 32'd2, 0, 0, 4, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("multu", MD_MULTU, 32'hFFFFFFFF, 32'd2, 0, 0, 4, 32'h00000001, 32'hFFFFFFFE);
    run_op("mult_neg", MD_MULT, 32'hFFFFFFFD, 32'd5, 0, 0, 4, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("div_m7", MD_DIV, 32'hFFFFFFF9, 32'd2, 0, 0, L_DIV7, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_5_2", MD_DIVU, 32'd5, 32'd2, 0, 0, L_DIVU5, 32'd1, 32'd2);
    run_op("div_100_m7", MD_DIV, 32'd100, 32'hFFFFFFF9, 0, 0, L_D100, 32'd2, 32'hFFFFFFF2);
    run_op("divu_full", MD_DIVU, 32'hFFFFFFFF, 32'd10, 0, 0, L_DFULL, 32'd5, 32'h19999999);
    run_op("div_zero_a", MD_DIV, 32'd0, 32'd5, 0, 0, L_ZERO, 32'd0, 32'd0);
    run_op("divu_by0", MD_DIVU, 32'd5, 32'd0, 0, 0, 1, 32'd5, 32'hFFFFFFFF);
    run_op("div_min", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 0, L_MIN, 32'd0, 32'h80000000);
    run_op("madd", MD_MADD, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 4, 32'd1, 32'd0);
    run_op("msub", MD_MSUB, 32'd1, 32'd1, 32'd0, 32'd0, 4, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op("msubu", MD_MSUBU, 32'd3, 32'd4, 32'd0, 32'd10, 4, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("maddu", MD_MADDU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd1, 4, 32'hFFFFFFFF, 32'h00000002);

    // valid_i while busy and in the DONE cycle must both be ignored.
    @(negedge clk);
    drive(MD_MULT, 32'd2, 32'd3, 0, 0);
    @(negedge clk);
    drive(MD_DIVU, 32'd7, 32'd0, 0, 0);
    chk("ign.busy1", busy_o, 1);
    @(negedge clk);
    scramble();
    chk("ign.busy2", busy_o, 1);
    chk("ign.ok2", ok_o, 0);
    @(negedge clk);
    chk("ign.ok3", ok_o, 0);
    @(negedge clk);
    chk("ign.ok4", ok_o, 1);
    chk("ign.lo4", lo_o, 6);
    chk("ign.hi4", hi_o, 0);
    drive(MD_MULTU, 32'd3, 32'd3, 0, 0);
    @(negedge clk);
    scramble();
    chk("ign.busy5", busy_o, 0);
    for (int k = 6; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("ign.ok@%0d", k), ok_o, 0);
      chk($sformatf("ign.busy@%0d", k), busy_o, 0);
    end
    chk("ign.lo_hold", lo_o, 6);

    // Flush mid-divide, then a multiply accepted straight after.
    @(negedge clk);
    drive(MD_DIVU, 32'hFFFFFF00, 32'd7, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) scramble();
      chk($sformatf("flush.busy@%0d", k), busy_o, 1);
      chk($sformatf("flush.ok@%0d", k), ok_o, 0);
      if (k == 10) flush_i = 1'b1;
    end
    @(negedge clk);
    flush_i = 1'b0;
    chk("flush.busy11", busy_o, 0);
    chk("flush.ok11", ok_o, 0);
    chk("flush.hi11", hi_o, 0);
    chk("flush.lo11", lo_o, 6);
    drive(MD_MULTU, 32'd3, 32'd4, 0, 0);
    for (int k = 12; k <= 15; k++) begin
      @(negedge clk);
      if (k == 12) scramble();
      if (k < 15) chk($sformatf("flush.mul_ok@%0d", k), ok_o, 0);
    end
    chk("flush.mul_ok", ok_o, 1);
    chk("flush.mul_hi", hi_o, 0);
    chk("flush.mul_lo", lo_o, 12);

    // flush_i together with valid_i in IDLE: no start.
    @(negedge clk);
    @(negedge clk);
    drive(MD_MULTU, 32'd7, 32'd7, 0, 0);
    flush_i = 1'b1;
    @(negedge clk);
    scramble();
    flush_i = 1'b0;
    chk("fv.busy", busy_o, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("fv.ok@%0d", k), ok_o, 0);
    end
    chk("fv.lo_hold", lo_o, 12);

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    drive(MD_MULTU, 32'd5, 32'd5, 0, 0);
    @(negedge clk);
    scramble();
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("rstmid.busy", busy_o, 0);
    chk("rstmid.ok", ok_o, 0);
    chk("rstmid.hi", hi_o, 0);
    chk("rstmid.lo", lo_o, 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (6) @(negedge clk);
    chk("rstmid.no_ok", ok_o, 0);
    chk("rstmid.lo_after", lo_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
